// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one external GCD engine (controller + datapath) between
// NREQ requesters with round-robin arbitration. Each accepted job latches its
// operands, clears the engine, starts it and waits for its level-held done.
// Zero operands are answered locally. A watchdog aborts jobs whose engine
// never reports done.
//
// Output timing: gnt is high in the cycle after the accept cycle. rsp_valid,
// rsp_data and rsp_err are registered while the FSM sits in RESP, so they are
// high in the cycle after RESP, which is already an IDLE cycle. That gives a
// bypass response two cycles after accept.
module gcd_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] x_in,
   input  logic [NREQ*WIDTH-1:0] y_in,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  gcd_clr,
   output logic                  gcd_start,
   output logic [WIDTH-1:0]      gcd_x,
   output logic [WIDTH-1:0]      gcd_y,
   input  logic                  gcd_done,
   input  logic [WIDTH-1:0]      gcd_result
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            state;
   logic [PTR_W-1:0]  ptr;
   logic [NREQ-1:0]   idx_oh;     // owner of the job in flight, one-hot
   logic [CNT_W-1:0]  counter;    // WAIT-cycle watchdog
   logic [WIDTH-1:0]  result;
   logic              err;

   logic              sel_found;
   logic [NREQ-1:0]   sel_oh;
   logic [PTR_W-1:0]  sel_next;
   logic [WIDTH-1:0]  sel_x;
   logic [WIDTH-1:0]  sel_y;

   // Round-robin pick: first request at or after ptr, else wrap to the lowest one.
   always_comb begin
      // NOTE: every variable gets a default before the loops so no path leaves it
      // unassigned, which would otherwise infer a latch.
      sel_found = 1'b0;
      sel_oh    = '0;
      sel_next  = '0;
      sel_x     = '0;
      sel_y     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!sel_found && req[i] && (PTR_W'(i) >= ptr)) begin
            sel_found = 1'b1;
            sel_oh[i] = 1'b1;
            sel_next  = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            sel_x     = x_in[i*WIDTH +: WIDTH];
            sel_y     = y_in[i*WIDTH +: WIDTH];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!sel_found && req[i]) begin
            sel_found = 1'b1;
            sel_oh[i] = 1'b1;
            sel_next  = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            sel_x     = x_in[i*WIDTH +: WIDTH];
            sel_y     = y_in[i*WIDTH +: WIDTH];
         end
      end
   end

   // Job FSM: accept, clear engine, wait for done or watchdog, respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         idx_oh    <= '0;
         counter   <= '0;
         result    <= '0;
         err       <= 1'b0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         gcd_x     <= '0;
         gcd_y     <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register in this
         // block updates from the values present before the edge.
         gnt       <= '0;
         rsp_valid <= '0;
         unique case (state)
            ST_IDLE: begin
               if (sel_found) begin
                  gcd_x  <= sel_x;
                  gcd_y  <= sel_y;
                  idx_oh <= sel_oh;
                  ptr    <= sel_next;
                  gnt    <= sel_oh;
                  err    <= 1'b0;
                  if (sel_x == '0 || sel_y == '0) begin
                     // The engine never terminates on a zero operand: answer here.
                     result <= (sel_x == '0) ? sel_y : sel_x;
                     state  <= ST_RESP;
                  end else begin
                     state  <= ST_CLEAR;
                  end
               end
            end
            ST_CLEAR: begin
               counter <= '0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               counter <= counter + 1'b1;
               if (gcd_done) begin
                  // Done wins over a watchdog expiring in the same cycle.
                  result <= gcd_result;
                  err    <= 1'b0;
                  state  <= ST_RESP;
               end else if (counter == CNT_LAST) begin
                  result <= '0;
                  err    <= 1'b1;
                  state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               rsp_valid <= idx_oh;
               rsp_data  <= result;
               rsp_err   <= err;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Engine strobes and busy decode straight from the registered state.
   assign busy      = (state != ST_IDLE);
   assign gcd_clr   = (state == ST_CLEAR);
   assign gcd_start = (state == ST_WAIT);

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed self-checking bench for gcd_arbiter. A small
// behavioural engine answers jobs a fixed number of start cycles after
// clear, and can be told to hang so the watchdog path is exercised.
module tb_gcd_arbiter;

   localparam int WIDTH   = 8;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   localparam int ENG_LAT = 3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] x_in = '0;
   logic [NREQ*WIDTH-1:0] y_in = '0;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic                  gcd_clr;
   logic                  gcd_start;
   logic [WIDTH-1:0]      gcd_x;
   logic [WIDTH-1:0]      gcd_y;
   logic                  gcd_done;
   logic [WIDTH-1:0]      gcd_result;

   int n_checks = 0;
   int n_fail   = 0;
   bit stuck    = 1'b0;
   int eng_cnt;

   gcd_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .x_in       (x_in),
      .y_in       (y_in),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .gcd_clr    (gcd_clr),
      .gcd_start  (gcd_start),
      .gcd_x      (gcd_x),
      .gcd_y      (gcd_y),
      .gcd_done   (gcd_done),
      .gcd_result (gcd_result)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in);
      logic [WIDTH-1:0] a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Behavioural engine: done rises ENG_LAT start cycles after clear, held until next clear.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcd_done   <= 1'b0;
         gcd_result <= '0;
         eng_cnt    <= 0;
      end else if (gcd_clr) begin
         gcd_done <= 1'b0;
         eng_cnt  <= 0;
      end else if (gcd_start && !gcd_done && !stuck) begin
         eng_cnt <= eng_cnt + 1;
         if (eng_cnt == ENG_LAT - 1) begin
            gcd_done   <= 1'b1;
            gcd_result <= gcd_ref(gcd_x, gcd_y);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      x_in[i*WIDTH +: WIDTH] = x;
      y_in[i*WIDTH +: WIDTH] = y;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   // Advance until a response appears or the budget runs out; tallies engine strobes seen.
   task automatic wait_rsp(input int max_cyc, output bit seen, output int clr_cnt, output int start_cnt);
      seen      = 1'b0;
      clr_cnt   = 0;
      start_cnt = 0;
      for (int c = 0; c < max_cyc && !seen; c++) begin
         tick();
         if (gcd_clr)         clr_cnt++;
         if (gcd_start)       start_cnt++;
         if (rsp_valid != '0) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
      n_checks++; if (rsp_data !== 8'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got data %0d err %b expected 0 0", rsp_data, rsp_err); end
      n_checks++; if (gcd_clr !== 1'b0 || gcd_start !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got clr %b start %b expected 0 0", gcd_clr, gcd_start); end
      n_checks++; if (gcd_x !== 8'd0 || gcd_y !== 8'd0) begin n_fail++; $display("FAIL reset_ops: got x %0d y %0d expected 0 0", gcd_x, gcd_y); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single_job();
      bit seen;
      int clr_cnt, start_cnt;
      set_ops(2, 8'd48, 8'd18);
      req = 4'b0100;
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
      n_checks++; if (gcd_clr !== 1'b1) begin n_fail++; $display("FAIL single_clr: got %b expected 1", gcd_clr); end
      n_checks++; if (gcd_x !== 8'd48 || gcd_y !== 8'd18) begin n_fail++; $display("FAIL single_ops: got x %0d y %0d expected 48 18", gcd_x, gcd_y); end
      req = '0;
      wait_rsp(100, seen, clr_cnt, start_cnt);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got no response expected one"); end
      n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
      n_checks++; if (rsp_data !== 8'd6 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp: got data %0d err %b expected 6 0", rsp_data, rsp_err); end
      n_checks++; if (clr_cnt !== 0) begin n_fail++; $display("FAIL single_clr_once: got %0d extra clear cycles expected 0", clr_cnt); end
      tick();
      n_checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_after: got busy %b rsp_valid %b expected 0 0000", busy, rsp_valid); end
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0]  exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [WIDTH-1:0] exp_dat [5] = '{8'd4, 8'd7, 8'd6, 8'd25, 8'd4};
      int n_gnt = 0;
      int n_rsp = 0;
      logic [NREQ-1:0] last_gnt = '0;
      do_reset();
      set_ops(0, 8'd12, 8'd8);
      set_ops(1, 8'd21, 8'd14);
      set_ops(2, 8'd48, 8'd18);
      set_ops(3, 8'd100, 8'd75);
      req = 4'b1111;
      for (int c = 0; c < 300 && n_rsp < 5; c++) begin
         tick();
         if (gnt != '0) begin
            n_checks++; if (n_gnt >= 5 || gnt !== exp_gnt[n_gnt]) begin n_fail++; $display("FAIL fair_gnt%0d: got %b expected %b", n_gnt, gnt, exp_gnt[n_gnt % 5]); end
            last_gnt = gnt;
            n_gnt++;
            if (n_gnt == 5) req = '0;
         end
         if (rsp_valid != '0) begin
            n_checks++; if (rsp_valid !== last_gnt) begin n_fail++; $display("FAIL fair_rsp%0d: got %b expected %b", n_rsp, rsp_valid, last_gnt); end
            n_checks++; if (rsp_data !== exp_dat[n_rsp % 5] || rsp_err !== 1'b0) begin n_fail++; $display("FAIL fair_data%0d: got %0d err %b expected %0d 0", n_rsp, rsp_data, rsp_err, exp_dat[n_rsp % 5]); end
            n_rsp++;
         end
      end
      req = '0;
      n_checks++; if (n_rsp !== 5) begin n_fail++; $display("FAIL fair_count: got %0d responses expected 5", n_rsp); end
      tick();
   endtask

   task automatic test_zero_bypass();
      logic [WIDTH-1:0] xs [3] = '{8'd0, 8'd0, 8'd77};
      logic [WIDTH-1:0] ys [3] = '{8'd35, 8'd0, 8'd0};
      logic [WIDTH-1:0] ex [3] = '{8'd35, 8'd0, 8'd77};
      int               rq [3] = '{1, 1, 0};
      bit touched = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_ops(rq[k], xs[k], ys[k]);
         req = '0;
         req[rq[k]] = 1'b1;
         tick();
         touched |= gcd_clr | gcd_start;
         n_checks++; if (gnt[rq[k]] !== 1'b1 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL bypass%0d_gnt: got gnt %b rsp_valid %b expected req %0d granted, no rsp", k, gnt, rsp_valid, rq[k]); end
         req = '0;
         tick();
         touched |= gcd_clr | gcd_start;
         n_checks++; if (rsp_valid[rq[k]] !== 1'b1 || rsp_data !== ex[k] || rsp_err !== 1'b0) begin n_fail++; $display("FAIL bypass%0d_rsp: got valid %b data %0d err %b expected data %0d err 0", k, rsp_valid, rsp_data, rsp_err, ex[k]); end
      end
      tick();
      touched |= gcd_clr | gcd_start;
      n_checks++; if (touched !== 1'b0) begin n_fail++; $display("FAIL bypass_engine: got engine strobed expected untouched"); end
   endtask

   task automatic test_timeout();
      bit seen;
      int clr_cnt, start_cnt;
      stuck = 1'b1;
      set_ops(0, 8'd9, 8'd6);
      req = 4'b0001;
      tick();
      req = '0;
      wait_rsp(100, seen, clr_cnt, start_cnt);
      n_checks++; if (seen !== 1'b1 || rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL timeout_valid: got %b expected 0001", rsp_valid); end
      n_checks++; if (rsp_err !== 1'b1 || rsp_data !== 8'd0) begin n_fail++; $display("FAIL timeout_rsp: got err %b data %0d expected 1 0", rsp_err, rsp_data); end
      n_checks++; if (start_cnt !== TIMEOUT) begin n_fail++; $display("FAIL timeout_wait_cycles: got %0d expected %0d", start_cnt, TIMEOUT); end
      stuck = 1'b0;
      tick();
      set_ops(3, 8'd100, 8'd75);
      req = 4'b1000;
      tick();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL timeout_next_gnt: got %b expected 1000", gnt); end
      req = '0;
      wait_rsp(100, seen, clr_cnt, start_cnt);
      n_checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 8'd25 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL timeout_next_rsp: got valid %b data %0d err %b expected 1000 25 0", rsp_valid, rsp_data, rsp_err); end
      tick();
   endtask

   task automatic test_equal_operands();
      bit seen;
      int clr_cnt, start_cnt;
      set_ops(2, 8'd255, 8'd255);
      req = 4'b0100;
      tick();
      req = '0;
      wait_rsp(100, seen, clr_cnt, start_cnt);
      n_checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 8'd255 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL equal_rsp: got valid %b data %0d err %b expected 0100 255 0", rsp_valid, rsp_data, rsp_err); end
      n_checks++; if (start_cnt !== ENG_LAT + 1) begin n_fail++; $display("FAIL equal_wait_cycles: got %0d expected %0d", start_cnt, ENG_LAT + 1); end
      tick();
   endtask

   task automatic test_reset_mid_job();
      bit seen;
      bit rsp_during = 1'b0;
      int clr_cnt, start_cnt;
      set_ops(1, 8'd30, 8'd12);
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      n_checks++; if (gcd_start !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait: got start %b expected 1", gcd_start); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({gnt, rsp_valid, rsp_data, rsp_err, gcd_clr, gcd_start, gcd_x, gcd_y, busy} !== '0) begin n_fail++; $display("FAIL midrst_outputs: got rsp_data %0d busy %b start %b x %0d y %0d expected all 0", rsp_data, busy, gcd_start, gcd_x, gcd_y); end
      repeat (3) begin
         tick();
         rsp_during |= (rsp_valid != '0);
      end
      #3 rst_n = 1'b1;
      set_ops(3, 8'd100, 8'd75);
      req = 4'b1010;
      tick();
      rsp_during |= (rsp_valid != '0);
      n_checks++; if (rsp_during !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp: got a response for the abandoned job expected none"); end
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_ptr_restart: got %b expected 0010", gnt); end
      req = 4'b1000;
      wait_rsp(100, seen, clr_cnt, start_cnt);
      n_checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 8'd6) begin n_fail++; $display("FAIL midrst_rsp1: got valid %b data %0d expected 0010 6", rsp_valid, rsp_data); end
      tick();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL midrst_gnt3: got %b expected 1000", gnt); end
      req = '0;
      wait_rsp(100, seen, clr_cnt, start_cnt);
      n_checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 8'd25 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp3: got valid %b data %0d err %b expected 1000 25 0", rsp_valid, rsp_data, rsp_err); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_fairness();
      test_zero_bypass();
      test_timeout();
      test_equal_operands();
      test_reset_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion expected finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Shares one GCD engine (controller plus datapath) between NREQ requesters using round-robin arbitration.
- Captures the granted requester's operands and clears the engine before each job.
- Drives the engine's start and watches its level-held done, then returns the result to the owning requester.
- Resolves zero operands locally (the engine would never terminate on them) and aborts hung jobs with a watchdog.

Parameters:
- WIDTH, 8, operand/result width in bits
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1024, maximum cycles in WAIT before abort (>=16)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- req  input  NREQ  per-requester job request, level
- x_in  input  NREQ*WIDTH  requester i's X operand in bits [i*WIDTH +: WIDTH]
- y_in  input  NREQ*WIDTH  requester i's Y operand, same packing
- gnt  output  NREQ  one-hot, 1-cycle pulse: operands of that requester captured
- rsp_valid  output  NREQ  one-hot, 1-cycle pulse: result for that requester
- rsp_data  output  WIDTH  result, valid with rsp_valid
- rsp_err  output  1  timeout flag, valid with rsp_valid
- busy  output  1  high in every state except IDLE
- gcd_clr  output  1  synchronous clear to engine (engine rst)
- gcd_start  output  1  engine start
- gcd_x, gcd_y  output  WIDTH  engine operands, stable CLEAR through WAIT
- gcd_done  input  1  engine done, held high until cleared
- gcd_result  input  WIDTH  engine result register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, counter=0.
  - gnt, rsp_valid, rsp_data, rsp_err, gcd_clr, gcd_start, gcd_x, gcd_y all 0.
  - Reset mid-job abandons the job with no rsp_valid.
- Outputs are registered; gcd_clr and gcd_start are decoded from the registered state.
- States: IDLE, CLEAR, WAIT, RESP.
- IDLE:
  - If any req is high, select the first requester i set at or after ptr (wrapping modulo NREQ).
  - Latch x_in[i] and y_in[i] into gcd_x/gcd_y; store idx=i.
  - Pulse gnt[i] in the next cycle; set ptr=(i+1) mod NREQ.
  - Next state: if either operand is 0, go to RESP (bypass); otherwise go to CLEAR.
- Request protocol:
  - A request is consumed at grant.
  - A requester wanting one job deasserts req the cycle after seeing gnt.
  - If req is still high when the arbiter next returns to IDLE, that is a new request.
  - Operands need only be stable in the accept cycle.
- CLEAR: gcd_clr=1 for exactly 1 cycle; counter=0; next state is WAIT.
- WAIT:
  - gcd_start=1, counter increments each cycle.
  - If gcd_done=1: capture gcd_result, err=0, go to RESP.
  - Else if counter==TIMEOUT-1: result=0, err=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - For 1 cycle: rsp_valid[idx]=1, rsp_data=result, rsp_err=err; gcd_start=0.
  - Next state is IDLE.
  - rsp_data holds its value until the next RESP.
- Bypass results:
  - x=0, y=0 gives 0.
  - x=0 gives y.
  - y=0 gives x.
  - err=0; the engine is not touched.
- Latency:
  - Bypass: accept cycle T, gnt at T+1, rsp_valid at T+2.
  - Engine job: rsp_valid one cycle after the cycle in which WAIT sees gcd_done.
- Other rules:
  - req arriving in non-IDLE states is ignored until IDLE; no queueing.
  - Back-to-back jobs: minimum one IDLE cycle between RESP and the next CLEAR.

Test Plan:
- Single job: req[2], x=48, y=18 → gnt=4'b0100 one cycle; gcd_clr pulse; rsp_valid=4'b0100, rsp_data=6, rsp_err=0; busy low afterward.
- Fairness: req=4'b1111 held for 4 jobs from reset → grant order 0,1,2,3, then 0 again; each rsp_valid matches its grant.
- Zero bypass: req[1], x=0, y=35 → rsp_data=35 two cycles after accept; gcd_clr and gcd_start never asserted. Also x=0, y=0 → rsp_data=0.
- Timeout: stub engine with gcd_done stuck 0, TIMEOUT=16 → rsp_valid after 16 WAIT cycles, rsp_err=1, rsp_data=0; next job proceeds normally.
- Reset mid-job: drop rst_n during WAIT → all outputs 0 immediately; no rsp_valid. After release, req[3] is granted and ptr restarts at 0.
- Equal operands: x=y=255 → rsp_data=255; engine done captured; no timeout.
